// File: rtl/timer_pkg.sv
// Shared constants and types for the multi-channel timer bank.
// Register map, CTRL bit layout and channel mode encoding.
package timer_pkg;

    localparam logic [1:0] REG_RELOAD   = 2'd0;
    localparam logic [1:0] REG_CTRL     = 2'd1;
    localparam logic [1:0] REG_PRESCALE = 2'd2;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IE   = 2;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // Field order mirrors the CTRL bit positions above (ie is the MSB).
    typedef struct packed {
        logic ie;
        logic mode;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: RELOAD, CTRL, counter and sticky pending.
// Expiry is evaluated on prescaler ticks; irq is registered as pending & ie.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             wr_reload,
    input  logic             wr_ctrl,
    input  logic [CNT_W-1:0] wr_data,
    input  ctrl_t            ctrl_data,
    input  logic             ack,
    output logic             irq,
    output logic             active,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] reload_r;
    logic [CNT_W-1:0] count_r;
    logic             en_r;
    logic             mode_r;
    logic             ie_r;
    logic             pend_r;
    logic             irq_r;

    logic [CNT_W-1:0] count_s;
    logic             en_s;
    logic             mode_s;
    logic             ie_s;
    logic             pend_s;
    logic             expire_s;

    // Counter/enable next state: a start load or a stop beats any tick.
    always_comb begin
        count_s  = count_r;
        en_s     = en_r;
        expire_s = 1'b0;
        if (wr_ctrl && ctrl_data.en && !en_r) begin
            count_s = reload_r;
            en_s    = 1'b1;
        end else if (wr_ctrl && !ctrl_data.en) begin
            en_s = 1'b0;
        end else if (en_r && tick) begin
            if (count_r != {CNT_W{1'b0}}) begin
                count_s = count_r - CNT_W'(1'b1);
            end else begin
                expire_s = 1'b1;
                if (mode_r == MODE_PERIODIC) begin
                    count_s = reload_r;
                end else begin
                    en_s = 1'b0;
                end
            end
        end else begin
            count_s = count_r;
        end
    end

    // Mode/ie follow every CTRL write; pending set beats a same-cycle ack.
    always_comb begin
        if (wr_ctrl) begin
            mode_s = ctrl_data.mode;
            ie_s   = ctrl_data.ie;
        end else begin
            mode_s = mode_r;
            ie_s   = ie_r;
        end
        pend_s = (pend_r & ~ack) | expire_s;
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            reload_r <= {CNT_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            en_r     <= 1'b0;
            mode_r   <= 1'b0;
            ie_r     <= 1'b0;
            pend_r   <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            if (wr_reload) begin
                reload_r <= wr_data;
            end
            count_r <= count_s;
            en_r    <= en_s;
            mode_r  <= mode_s;
            ie_r    <= ie_s;
            pend_r  <= pend_s;
            irq_r   <= pend_s & ie_s;
        end
    end

    assign irq    = irq_r;
    assign active = en_r;
    assign count  = count_r;

endmodule

// File: rtl/timer_bank.sv
// NCH-channel programmable timer sharing one prescaler, driven from the
// CPU output-port write path and feeding per-channel interrupt requests.
module timer_bank
    import timer_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int CNT_W = 8,
    parameter  int PRE_W = 8,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int DW    = (CNT_W > PRE_W) ? CNT_W : PRE_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [1:0]           wr_reg,
    input  logic [DW-1:0]        wr_data,
    input  logic [NCH-1:0]       int_ack,
    output logic [NCH-1:0]       irq,
    output logic [NCH-1:0]       active,
    output logic [NCH*CNT_W-1:0] count
);

    logic [PRE_W-1:0] pre_r;
    logic [PRE_W-1:0] pcnt_r;
    logic             tick_s;
    logic             wr_pre_s;
    logic [NCH-1:0]   wr_reload_s;
    logic [NCH-1:0]   wr_ctrl_s;
    ctrl_t            ctrl_s;

    assign tick_s   = (pcnt_r == pre_r);
    assign wr_pre_s = wr_en && (wr_reg == REG_PRESCALE);
    assign ctrl_s   = ctrl_t'(wr_data[CTRL_IE:CTRL_EN]);

    // Per-channel write strobes; the reserved register select decodes to nothing.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wr_reload_s[i] = wr_en && (wr_ch == CH_W'(i)) && (wr_reg == REG_RELOAD);
            wr_ctrl_s[i]   = wr_en && (wr_ch == CH_W'(i)) && (wr_reg == REG_CTRL);
        end
    end

    // Prescaler: counts 0..PRESCALE, restarted whenever PRESCALE is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_r  <= {PRE_W{1'b0}};
            pcnt_r <= {PRE_W{1'b0}};
        end else if (wr_pre_s) begin
            pre_r  <= wr_data[PRE_W-1:0];
            pcnt_r <= {PRE_W{1'b0}};
        end else if (tick_s) begin
            pcnt_r <= {PRE_W{1'b0}};
        end else begin
            pcnt_r <= pcnt_r + PRE_W'(1'b1);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick_s),
            .wr_reload (wr_reload_s[g]),
            .wr_ctrl   (wr_ctrl_s[g]),
            .wr_data   (wr_data[CNT_W-1:0]),
            .ctrl_data (ctrl_s),
            .ack       (int_ack[g]),
            .irq       (irq[g]),
            .active    (active[g]),
            .count     (count[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed table, hand sequences for
// multi-cycle corners, and randomized traffic against a behavioural model.
module tb_timer_bank;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;
    localparam int PRE_W = 8;

    logic                 clk;
    logic                 reset;
    logic                 wr_en;
    logic [1:0]           wr_ch;
    logic [1:0]           wr_reg;
    logic [7:0]           wr_data;
    logic [NCH-1:0]       int_ack;
    logic [NCH-1:0]       irq;
    logic [NCH-1:0]       active;
    logic [NCH*CNT_W-1:0] count;

    timer_bank #(.NCH(NCH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_reg  (wr_reg),
        .wr_data (wr_data),
        .int_ack (int_ack),
        .irq     (irq),
        .active  (active),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    logic [NCH-1:0] last_irq = '0;
    int rise0[$];
    int rise3[$];

    // Reference model: plain per-channel integers following the timer rules.
    int m_rel[NCH], m_cnt[NCH], m_en[NCH], m_mode[NCH], m_ie[NCH], m_pend[NCH];
    int m_pre, m_pcnt;

    typedef struct {
        logic       we;
        logic [1:0] ch;
        logic [1:0] rg;
        logic [7:0] d;
        logic [3:0] ak;
        logic [3:0] e_irq;
        logic [3:0] e_act;
        logic [7:0] e_cnt0;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic model_step(input logic we, input logic [1:0] ch, input logic [1:0] rg,
                              input logic [7:0] d, input logic [3:0] ak, input logic rst);
        bit tk, wc, ex;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_rel[i] = 0; m_cnt[i] = 0; m_en[i] = 0;
                m_mode[i] = 0; m_ie[i] = 0; m_pend[i] = 0;
            end
            m_pre = 0; m_pcnt = 0;
            return;
        end
        tk = (m_pcnt == m_pre);
        for (int i = 0; i < NCH; i++) begin
            wc = we && (rg == 2'd1) && (ch == i);
            ex = 0;
            if (wc && d[0] && m_en[i] == 0) begin
                m_cnt[i] = m_rel[i];
                m_en[i]  = 1;
            end else if (wc && !d[0]) begin
                m_en[i] = 0;
            end else if (m_en[i] != 0 && tk) begin
                if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                else begin
                    ex = 1;
                    if (m_mode[i] != 0) m_cnt[i] = m_rel[i];
                    else m_en[i] = 0;
                end
            end
            if (wc) begin
                m_mode[i] = int'(d[1]);
                m_ie[i]   = int'(d[2]);
            end
            m_pend[i] = ((m_pend[i] != 0 && !ak[i]) || ex) ? 1 : 0;
            if (we && rg == 2'd0 && ch == i) m_rel[i] = int'(d);
        end
        if (we && rg == 2'd2) begin
            m_pre = int'(d); m_pcnt = 0;
        end else if (tk) m_pcnt = 0;
        else m_pcnt = m_pcnt + 1;
    endtask

    function automatic logic [NCH-1:0] m_irq_vec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = (m_pend[i] != 0) && (m_ie[i] != 0);
        return v;
    endfunction

    function automatic logic [NCH-1:0] m_act_vec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = (m_en[i] != 0);
        return v;
    endfunction

    function automatic logic [NCH*CNT_W-1:0] m_cnt_vec();
        logic [NCH*CNT_W-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        return v;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_of(input int i);
        return count[i*CNT_W +: CNT_W];
    endfunction

    // One clock: drive, advance the model on the edge, sample #1 later.
    task automatic cyc(input logic we, input logic [1:0] ch, input logic [1:0] rg,
                       input logic [7:0] d, input logic [3:0] ak);
        wr_en = we; wr_ch = ch; wr_reg = rg; wr_data = d; int_ack = ak;
        @(posedge clk);
        model_step(we, ch, rg, d, ak, reset);
        #1;
        cyc_n++;
        chk("model_irq", 32'(irq), 32'(m_irq_vec()));
        chk("model_active", 32'(active), 32'(m_act_vec()));
        chk("model_count", 32'(count), 32'(m_cnt_vec()));
        if (irq[0] && !last_irq[0]) rise0.push_back(cyc_n);
        if (irq[3] && !last_irq[3]) rise3.push_back(cyc_n);
        last_irq = irq;
    endtask

    task automatic idle_ack(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 2'd0, 2'd0, 8'd0, last_irq);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_irq"}, 32'(irq), 32'd0);
        chk({nm, "_active"}, 32'(active), 32'd0);
        chk({nm, "_count"}, count, 32'd0);
    endtask

    initial begin
        int n_pre;
        bit done;
        logic [1:0] rg;
        reset = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_reg = '0; wr_data = '0; int_ack = '0;
        model_step(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 1'b1);

        // Reset and defaults
        cyc(1'b0, 2'd0, 2'd0, 8'd0, 4'd0);
        cyc(1'b0, 2'd0, 2'd0, 8'd0, 4'd0);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 2'd0, 2'd0, 8'd0, 4'd0);
            chk_zero("defaults");
        end

        // Periodic ch0, RELOAD=3, PRESCALE=0
        tbl[0]  = '{1'b1, 2'd0, 2'd0, 8'd3, 4'h0, 4'h0, 4'h0, 8'd0};
        tbl[1]  = '{1'b1, 2'd0, 2'd2, 8'd0, 4'h0, 4'h0, 4'h0, 8'd0};
        tbl[2]  = '{1'b1, 2'd0, 2'd1, 8'd7, 4'h0, 4'h0, 4'h1, 8'd3};
        tbl[3]  = '{1'b0, 2'd0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h1, 8'd2};
        tbl[4]  = '{1'b0, 2'd0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h1, 8'd1};
        tbl[5]  = '{1'b0, 2'd0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h1, 8'd0};
        tbl[6]  = '{1'b0, 2'd0, 2'd0, 8'd0, 4'h0, 4'h1, 4'h1, 8'd3};
        tbl[7]  = '{1'b0, 2'd0, 2'd0, 8'd0, 4'h1, 4'h0, 4'h1, 8'd2};
        tbl[8]  = '{1'b0, 2'd0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h1, 8'd1};
        tbl[9]  = '{1'b0, 2'd0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h1, 8'd0};
        tbl[10] = '{1'b0, 2'd0, 2'd0, 8'd0, 4'h0, 4'h1, 4'h1, 8'd3};
        tbl[11] = '{1'b0, 2'd0, 2'd0, 8'd0, 4'h1, 4'h0, 4'h1, 8'd2};
        tbl[12] = '{1'b1, 2'd0, 2'd1, 8'd0, 4'h0, 4'h0, 4'h0, 8'd2};
        for (int r = 0; r < 13; r++) begin
            cyc(tbl[r].we, tbl[r].ch, tbl[r].rg, tbl[r].d, tbl[r].ak);
            chk($sformatf("tbl%0d_irq", r), 32'(irq), 32'(tbl[r].e_irq));
            chk($sformatf("tbl%0d_active", r), 32'(active), 32'(tbl[r].e_act));
            chk($sformatf("tbl%0d_count0", r), 32'(cnt_of(0)), 32'(tbl[r].e_cnt0));
        end

        // One-shot ch1, RELOAD=2, PRESCALE=4: expiry 15 cycles into the run
        cyc(1'b1, 2'd1, 2'd0, 8'd2, 4'h0);
        cyc(1'b1, 2'd0, 2'd2, 8'd4, 4'h0);
        cyc(1'b1, 2'd1, 2'd1, 8'd5, 4'h0);
        chk("oneshot_start_count", 32'(cnt_of(1)), 32'd2);
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b0, 2'd0, 2'd0, 8'd0, 4'h0);
            chk("oneshot_irq1", 32'(irq[1]), (k >= 14) ? 32'd1 : 32'd0);
            chk("oneshot_active1", 32'(active[1]), (k >= 14) ? 32'd0 : 32'd1);
            chk("oneshot_count1", 32'(cnt_of(1)), (k < 4) ? 32'd2 : ((k < 9) ? 32'd1 : 32'd0));
        end
        cyc(1'b0, 2'd0, 2'd0, 8'd0, 4'h2);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 2'd0, 2'd0, 8'd0, 4'h0);
            chk("oneshot_after_irq1", 32'(irq[1]), 32'd0);
            chk("oneshot_after_active1", 32'(active[1]), 32'd0);
        end
        cyc(1'b1, 2'd0, 2'd2, 8'd0, 4'h0);

        // Masking and ack/expiry race on ch2 (RELOAD=0, periodic)
        cyc(1'b1, 2'd2, 2'd0, 8'd0, 4'h0);
        cyc(1'b1, 2'd2, 2'd1, 8'd3, 4'h0);
        chk("mask_active2", 32'(active[2]), 32'd1);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 2'd0, 2'd0, 8'd0, 4'h0);
            chk("mask_irq2", 32'(irq[2]), 32'd0);
        end
        cyc(1'b1, 2'd2, 2'd1, 8'd7, 4'h0);
        chk("unmask_irq2", 32'(irq[2]), 32'd1);
        cyc(1'b0, 2'd0, 2'd0, 8'd0, 4'h4);
        chk("ack_race_irq2", 32'(irq[2]), 32'd1);
        cyc(1'b1, 2'd2, 2'd1, 8'd0, 4'h4);
        chk("stop_ack_irq2", 32'(irq[2]), 32'd0);
        chk("stop_active2", 32'(active[2]), 32'd0);

        // Independence: ch0 RELOAD=1, ch3 RELOAD=5; ch0 RELOAD rewritten mid-run
        cyc(1'b1, 2'd0, 2'd0, 8'd1, 4'h0);
        cyc(1'b1, 2'd3, 2'd0, 8'd5, 4'h0);
        rise0.delete(); rise3.delete();
        cyc(1'b1, 2'd0, 2'd1, 8'd7, 4'h0);
        cyc(1'b1, 2'd3, 2'd1, 8'd7, last_irq);
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            cyc(1'b0, 2'd0, 2'd0, 8'd0, last_irq);
            if (k >= 12 && irq[0]) done = 1;
        end
        chk("indep_ch0_rise_seen", 32'(done), 32'd1);
        n_pre = rise0.size();
        cyc(1'b1, 2'd0, 2'd0, 8'd7, last_irq);
        idle_ack(40);
        for (int i = 1; i < n_pre; i++) chk("indep_ch0_period2", 32'(rise0[i] - rise0[i-1]), 32'd2);
        chk("indep_ch0_rises", 32'(rise0.size() >= n_pre + 3), 32'd1);
        if (rise0.size() >= n_pre + 3) begin
            chk("indep_ch0_last_old", 32'(rise0[n_pre] - rise0[n_pre-1]), 32'd2);
            for (int i = n_pre + 1; i < rise0.size(); i++)
                chk("indep_ch0_period8", 32'(rise0[i] - rise0[i-1]), 32'd8);
        end
        chk("indep_ch3_rises", 32'(rise3.size() >= 5), 32'd1);
        for (int i = 1; i < rise3.size(); i++) chk("indep_ch3_period6", 32'(rise3[i] - rise3[i-1]), 32'd6);

        // Reset mid-operation with all channels running, then restart ch0
        cyc(1'b1, 2'd1, 2'd1, 8'd7, last_irq);
        cyc(1'b1, 2'd2, 2'd1, 8'd7, last_irq);
        chk("all_running", 32'(active), 32'hF);
        idle_ack(7);
        reset = 1'b1;
        cyc(1'b0, 2'd0, 2'd0, 8'd0, 4'h0);
        reset = 1'b0;
        chk_zero("midreset");
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 2'd0, 2'd0, 8'd0, 4'h0);
            chk_zero("postreset");
        end
        cyc(1'b1, 2'd0, 2'd0, 8'd3, 4'h0);
        rise0.delete();
        cyc(1'b1, 2'd0, 2'd1, 8'd7, 4'h0);
        idle_ack(25);
        chk("restart_active", 32'(active), 32'h1);
        chk("restart_rises", 32'(rise0.size() >= 4), 32'd1);
        for (int i = 1; i < rise0.size(); i++) chk("restart_period4", 32'(rise0[i] - rise0[i-1]), 32'd4);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 399) == 0);
            rg = 2'($urandom_range(0, 3));
            cyc(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), rg,
                (rg == 2'd2) ? 8'($urandom_range(0, 3)) :
                ((rg == 2'd1) ? 8'($urandom) : 8'($urandom_range(0, 7))),
                ($urandom_range(0, 1) == 1) ? last_irq : 4'($urandom));
        end
        reset = 1'b0;
        cyc(1'b0, 2'd0, 2'd0, 8'd0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
